voxel_dispatcher: RTL and testbench

- Frame-level sequencer directly upstream of the pixel_shader array.
- On start, fetches the voxel list from voxel memory and broadcasts each voxel to all shaders via a four-phase do_rasterize handshake.
- Then runs one do_shade pass and scans every (row, col) over the shared pixel bus, writing each pixel into the framebuffer.

---
 rtl/voxel_gpu_pkg.sv | 45 ++++
 rtl/four_phase_req.sv | 51 +++++
 rtl/voxel_dispatcher.sv | 204 ++++++++++++++++++++
 tb/tb_voxel_dispatcher.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/voxel_gpu_pkg.sv
// voxel_gpu_pkg
// Shared types for the voxel dispatcher slice:
//   - state_e : dispatcher frame sequencer states
//   - phase_e : phases of a four-phase request/done handshake
//   - voxel_t : voxel memory word, packed {id, z, y, x} (x in the low byte)
//   - fbAddrCalc : framebuffer linear address for a (row, col) pixel
package voxel_gpu_pkg;

  localparam int VOX_COORD_BITS   = 8;
  localparam int VOX_PALETTE_BITS = 8;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_LATCH     = 4'd2,
    ST_RAST_REQ  = 4'd3,
    ST_RAST_REL  = 4'd4,
    ST_SHADE_REQ = 4'd5,
    ST_SHADE_REL = 4'd6,
    ST_READ      = 4'd7,
    ST_WRITE     = 4'd8,
    ST_DONE      = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_REQ  = 2'd1,
    PH_REL  = 2'd2
  } phase_e;

  typedef struct packed {
    logic [VOX_PALETTE_BITS-1:0] id;
    logic [VOX_COORD_BITS-1:0]   z;
    logic [VOX_COORD_BITS-1:0]   y;
    logic [VOX_COORD_BITS-1:0]   x;
  } voxel_t;

  // Row-major pixel address; callers truncate to their framebuffer width.
  function automatic logic [31:0] fbAddrCalc(input logic [31:0] row,
                                             input logic [31:0] col,
                                             input logic [31:0] numCols);
    return row * numCols + col;
  endfunction

endpackage

// File: rtl/four_phase_req.sv
// four_phase_req
// Drives one four-phase handshake: raises req_o the cycle after launch_i,
// drops it once done_i is seen high, then waits for done_i to fall before
// signalling completion. A done that is still high from an earlier request
// can never be mistaken for a fresh one because completion needs done low.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   launch_i     : one-cycle pulse starting a request
//   done_i       : combined done from the responders
//   req_o        : registered request
//   ack_o        : high in the cycle the release phase sees done_i low
module four_phase_req
  import voxel_gpu_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic launch_i,
  input  logic done_i,
  output logic req_o,
  output logic ack_o
);

  phase_e phase_q, phase_d;
  logic   req_q;

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE: if (launch_i) phase_d = PH_REQ;
      PH_REQ:  if (done_i)   phase_d = PH_REL;
      PH_REL:  if (!done_i)  phase_d = PH_IDLE;
      default: phase_d = PH_IDLE;
    endcase
  end

  // req follows the next phase so it rises together with the caller's
  // REQ state and falls the cycle done is first seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      req_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      req_q   <= (phase_d == PH_REQ);
    end
  end

  assign req_o = req_q;
  assign ack_o = (phase_q == PH_REL) && !done_i;

endmodule

// File: rtl/voxel_dispatcher.sv
// voxel_dispatcher
// Frame sequencer in front of the pixel_shader array. On start it fetches
// each voxel from voxel memory, broadcasts it with a four-phase
// do_rasterize handshake, runs one do_shade handshake, then reads every
// (row, col) off the shared pixel bus into the framebuffer.
// Ports:
//   clock, reset                 : clock, asynchronous active-high reset
//   start, num_voxels            : frame start and voxel count (IDLE only)
//   vmem_rd/addr/rdata           : voxel memory, rdata valid 1 cycle after rd
//   voxel_x/y/z/id, do_rasterize : voxel broadcast and rasterize request
//   all_rasterizing_done         : AND of shader rasterizing_done
//   do_shade, all_shading_done   : shade request and AND of shading_done
//   row, col, pixel              : shared pixel bus
//   fb_we/addr/data, fb_ready    : framebuffer write port
//   busy, frame_done             : status
module voxel_dispatcher
  import voxel_gpu_pkg::*;
#(
  parameter int NUM_ROWS     = 16,
  parameter int NUM_COLS     = 16,
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int COORD_BITS   = VOX_COORD_BITS,
  parameter int PALETTE_BITS = VOX_PALETTE_BITS,
  parameter int PIXEL_BITS   = 8,
  parameter int VADDR_BITS   = 12,
  parameter int FB_ADDR_BITS = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [VADDR_BITS:0]                  num_voxels,
  output logic                                 vmem_rd,
  output logic [VADDR_BITS-1:0]                vmem_addr,
  input  logic [3*COORD_BITS+PALETTE_BITS-1:0] vmem_rdata,
  output logic [COORD_BITS-1:0]                voxel_x,
  output logic [COORD_BITS-1:0]                voxel_y,
  output logic [COORD_BITS-1:0]                voxel_z,
  output logic [PALETTE_BITS-1:0]              voxel_id,
  output logic                                 do_rasterize,
  input  logic                                 all_rasterizing_done,
  output logic                                 do_shade,
  input  logic                                 all_shading_done,
  output logic [ROW_BITS-1:0]                  row,
  output logic [COL_BITS-1:0]                  col,
  input  logic [PIXEL_BITS-1:0]                pixel,
  output logic                                 fb_we,
  output logic [FB_ADDR_BITS-1:0]              fb_addr,
  output logic [PIXEL_BITS-1:0]                fb_data,
  input  logic                                 fb_ready,
  output logic                                 busy,
  output logic                                 frame_done
);

  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NUM_ROWS - 1);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(NUM_COLS - 1);

  state_e                  state_q, state_d;
  logic [VADDR_BITS:0]     numVoxels_q, numVoxels_d;
  logic [VADDR_BITS:0]     index_q, index_d;
  logic [ROW_BITS-1:0]     row_q, row_d;
  logic [COL_BITS-1:0]     col_q, col_d;
  logic                    vmemRd_q;
  logic [VADDR_BITS-1:0]   vmemAddr_q;
  voxel_t                  voxel_q;
  voxel_t                  rdVoxel;
  logic                    fbWe_q;
  logic [FB_ADDR_BITS-1:0] fbAddr_q;
  logic [FB_ADDR_BITS-1:0] fbAddrNext;
  logic [PIXEL_BITS-1:0]   fbData_q;
  logic                    busy_q;
  logic                    frameDone_q;
  logic                    rastLaunch, rastAck;
  logic                    shadeLaunch, shadeAck;

  assign rdVoxel    = vmem_rdata;
  assign fbAddrNext = FB_ADDR_BITS'(fbAddrCalc(32'(row_q), 32'(col_q), 32'(NUM_COLS)));

  // Handshakes launch on entry to their REQ state, from whichever state.
  assign rastLaunch  = (state_q != ST_RAST_REQ)  && (state_d == ST_RAST_REQ);
  assign shadeLaunch = (state_q != ST_SHADE_REQ) && (state_d == ST_SHADE_REQ);

  four_phase_req u_rastReq (
    .clock    (clock),
    .reset    (reset),
    .launch_i (rastLaunch),
    .done_i   (all_rasterizing_done),
    .req_o    (do_rasterize),
    .ack_o    (rastAck)
  );

  four_phase_req u_shadeReq (
    .clock    (clock),
    .reset    (reset),
    .launch_i (shadeLaunch),
    .done_i   (all_shading_done),
    .req_o    (do_shade),
    .ack_o    (shadeAck)
  );

  always_comb begin
    state_d     = state_q;
    numVoxels_d = numVoxels_q;
    index_d     = index_q;
    row_d       = row_q;
    col_d       = col_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          numVoxels_d = num_voxels;
          index_d     = '0;
          state_d     = (num_voxels == '0) ? ST_SHADE_REQ : ST_FETCH;
        end
      end
      ST_FETCH:     state_d = ST_LATCH;
      ST_LATCH:     state_d = ST_RAST_REQ;
      ST_RAST_REQ:  if (all_rasterizing_done) state_d = ST_RAST_REL;
      ST_RAST_REL: begin
        if (rastAck) begin
          index_d = index_q + 1'b1;
          state_d = (index_d == numVoxels_q) ? ST_SHADE_REQ : ST_FETCH;
        end
      end
      ST_SHADE_REQ: if (all_shading_done) state_d = ST_SHADE_REL;
      ST_SHADE_REL: begin
        if (shadeAck) begin
          row_d   = '0;
          col_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ:      state_d = ST_WRITE;
      ST_WRITE: begin
        if (fb_ready) begin
          state_d = ST_READ;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              state_d = ST_DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Every output is registered; strobes are derived from the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      numVoxels_q <= '0;
      index_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      vmemRd_q    <= 1'b0;
      vmemAddr_q  <= '0;
      voxel_q     <= '0;
      fbWe_q      <= 1'b0;
      fbAddr_q    <= '0;
      fbData_q    <= '0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      numVoxels_q <= numVoxels_d;
      index_q     <= index_d;
      row_q       <= row_d;
      col_q       <= col_d;
      vmemRd_q    <= (state_d == ST_FETCH);
      if (state_d == ST_FETCH) vmemAddr_q <= index_d[VADDR_BITS-1:0];
      if (state_q == ST_LATCH) voxel_q <= rdVoxel;
      if (state_q == ST_READ) begin
        fbData_q <= pixel;
        fbAddr_q <= fbAddrNext;
      end
      fbWe_q      <= (state_d == ST_WRITE);
      busy_q      <= (state_d != ST_IDLE);
      frameDone_q <= (state_d == ST_DONE);
    end
  end

  assign vmem_rd    = vmemRd_q;
  assign vmem_addr  = vmemAddr_q;
  assign voxel_x    = voxel_q.x;
  assign voxel_y    = voxel_q.y;
  assign voxel_z    = voxel_q.z;
  assign voxel_id   = voxel_q.id;
  assign row        = row_q;
  assign col        = col_q;
  assign fb_we      = fbWe_q;
  assign fb_addr    = fbAddr_q;
  assign fb_data    = fbData_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_voxel_dispatcher.sv
// tb_voxel_dispatcher
// Scoreboard bench for voxel_dispatcher on a 2x2 shader array. Stimulus
// pushes expected voxel reads and framebuffer writes into queues; a monitor
// on the falling edge pops and compares whenever the DUT strobes.
module tb_voxel_dispatcher;

  localparam int NR = 2;
  localparam int NC = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] num_voxels;
  logic        vmem_rd;
  logic [11:0] vmem_addr;
  logic [31:0] vmem_rdata = '0;
  logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id;
  logic        do_rasterize, do_shade;
  logic        rastDone = 1'b0;
  logic        shadeDone = 1'b0;
  logic [7:0]  row, col, pixel;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready = 1'b1;
  logic        busy, frame_done;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [0:7];
  int          vmemQ[$];
  logic [23:0] fbQ[$];
  logic [31:0] expVoxel = '0;
  int          shadeRises = 0;
  logic        shadePrev = 1'b0;
  int          writesDone = 0;
  int          framesSeen = 0;
  int          rastHold = 0;
  int          rastCnt = 0, rastHoldCnt = 0, shadeCnt = 0;
  int          weCycles = 0;
  bit          stallOn = 1'b0;

  always #5 clock = ~clock;

  voxel_dispatcher #(.NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .num_voxels           (num_voxels),
    .vmem_rd              (vmem_rd),
    .vmem_addr            (vmem_addr),
    .vmem_rdata           (vmem_rdata),
    .voxel_x              (voxel_x),
    .voxel_y              (voxel_y),
    .voxel_z              (voxel_z),
    .voxel_id             (voxel_id),
    .do_rasterize         (do_rasterize),
    .all_rasterizing_done (rastDone),
    .do_shade             (do_shade),
    .all_shading_done     (shadeDone),
    .row                  (row),
    .col                  (col),
    .pixel                (pixel),
    .fb_we                (fb_we),
    .fb_addr              (fb_addr),
    .fb_data              (fb_data),
    .fb_ready             (fb_ready),
    .busy                 (busy),
    .frame_done           (frame_done)
  );

  // Shader array answers every pixel select with row*16+col.
  assign pixel = {row[3:0], col[3:0]};

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(string name, logic [63:0] act);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=0x%0h required=none", name, act);
  endtask

  // Voxel memory returns the addressed word one cycle after the read strobe.
  always @(posedge clock) begin
    #1;
    if (reset) vmem_rdata = '0;
    else if (vmem_rd) vmem_rdata = mem[vmem_addr[2:0]];
  end

  // Rasterizer model: done two cycles into the request, optionally held
  // high for rastHold cycles after the request drops.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      rastDone = 1'b0; rastCnt = 0; rastHoldCnt = 0;
    end else if (do_rasterize) begin
      rastCnt++;
      if (rastCnt >= 2) rastDone = 1'b1;
    end else if (rastDone && rastHoldCnt < rastHold) begin
      rastHoldCnt++;
    end else begin
      rastDone = 1'b0; rastCnt = 0; rastHoldCnt = 0;
    end
  end

  // Shader model: done two cycles into do_shade, dropped right after.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      shadeDone = 1'b0; shadeCnt = 0;
    end else if (do_shade) begin
      shadeCnt++;
      if (shadeCnt >= 2) shadeDone = 1'b1;
    end else begin
      shadeDone = 1'b0; shadeCnt = 0;
    end
  end

  // Framebuffer back-pressure: the second write of a stalled frame waits
  // five cycles before being accepted.
  always @(posedge clock) begin
    #1;
    if (fb_we) weCycles++;
    else weCycles = 0;
    fb_ready = !(stallOn && writesDone == 1 && fb_we && weCycles <= 5);
  end

  // Monitor: pops expected reads/writes whenever the DUT strobes.
  always @(negedge clock) begin
    if (!reset) begin
      if (vmem_rd) begin
        if (vmemQ.size() == 0) reportUnexpected("vmem_rd_extra", 64'(vmem_addr));
        else begin
          int e;
          e = vmemQ.pop_front();
          checkOutput("vmem_addr", 64'(vmem_addr), 64'(e));
          expVoxel = mem[e];
        end
        checkOutput("fetch_with_rast_done_high", 64'(rastDone), 64'(0));
      end
      if (do_rasterize)
        checkOutput("voxel_stable", 64'({voxel_id, voxel_z, voxel_y, voxel_x}), 64'(expVoxel));
      if (do_shade && !shadePrev) shadeRises++;
      shadePrev = do_shade;
      if (fb_we) begin
        if (fbQ.size() == 0) reportUnexpected("fb_write_extra", 64'({fb_addr, fb_data}));
        else if (fb_ready) begin
          logic [23:0] e;
          e = fbQ.pop_front();
          checkOutput("fb_write", 64'({fb_addr, fb_data}), 64'(e));
          writesDone++;
        end else begin
          checkOutput("fb_stall_hold", 64'({fb_addr, fb_data}), 64'(fbQ[0]));
        end
      end
      if (frame_done) framesSeen++;
    end
  end

  task automatic checkAllZero(string name);
    checkOutput({name, "_a"}, 64'({vmem_rd, vmem_addr, voxel_x, voxel_y, voxel_z, voxel_id}), 64'(0));
    checkOutput({name, "_b"}, 64'({do_rasterize, do_shade, row, col, fb_we, fb_addr, fb_data,
                                    busy, frame_done}), 64'(0));
  endtask

  task automatic loadExpected(int nVox);
    vmemQ.delete();
    fbQ.delete();
    for (int i = 0; i < nVox; i++) vmemQ.push_back(i);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        fbQ.push_back({16'(r * NC + c), 8'(r * 16 + c)});
    shadeRises = 0;
    writesDone = 0;
    framesSeen = 0;
  endtask

  // Runs one full frame; optionally pulses start mid-frame, which must be
  // ignored.
  task automatic applyStimulus(int nVox, bit pulseWhileBusy);
    int cycles;
    int firstShade;
    loadExpected(nVox);
    @(negedge clock);
    num_voxels = 13'(nVox);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    num_voxels = 13'd5;
    cycles = 1;
    firstShade = do_shade ? 1 : 0;
    while (!frame_done && cycles < 2000) begin
      @(negedge clock);
      cycles++;
      start = (pulseWhileBusy && cycles == 10);
      if (do_shade && firstShade == 0) firstShade = cycles;
    end
    start = 1'b0;
    if (!frame_done) reportUnexpected("frame_timeout", 64'(cycles));
    if (nVox == 0) checkOutput("shade_latency", 64'(firstShade), 64'(1));
    @(negedge clock);
    checkOutput("frame_done_one_cycle", 64'(frame_done), 64'(0));
    checkOutput("busy_after_frame", 64'(busy), 64'(0));
    repeat (3) @(negedge clock);
    checkOutput("vmem_reads_left", 64'(vmemQ.size()), 64'(0));
    checkOutput("fb_writes_left", 64'(fbQ.size()), 64'(0));
    checkOutput("shade_count", 64'(shadeRises), 64'(1));
    checkOutput("frame_done_count", 64'(framesSeen), 64'(1));
  endtask

  initial begin
    int cycles;
    for (int i = 0; i < 8; i++)
      mem[i] = {8'(8'hA0 + i), 8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)};
    reset = 1'b1;
    start = 1'b0;
    num_voxels = '0;
    repeat (3) @(negedge clock);
    checkAllZero("reset_state");
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] three voxels");
    applyStimulus(3, 1'b0);

    $display("[TB] zero voxels");
    applyStimulus(0, 1'b0);

    $display("[TB] framebuffer stall");
    stallOn = 1'b1;
    applyStimulus(1, 1'b0);
    stallOn = 1'b0;

    $display("[TB] rasterizing_done held after release");
    rastHold = 3;
    applyStimulus(2, 1'b0);
    rastHold = 0;

    $display("[TB] reset during voxel 1 rasterize");
    loadExpected(3);
    @(negedge clock);
    num_voxels = 13'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cycles = 0;
    while (!(do_rasterize && vmemQ.size() == 1) && cycles < 200) begin
      @(negedge clock);
      cycles++;
    end
    if (cycles >= 200) reportUnexpected("voxel1_rast_timeout", 64'(cycles));
    reset = 1'b1;
    @(posedge clock);
    #1;
    checkAllZero("mid_frame_reset");
    @(negedge clock);
    reset = 1'b0;
    vmemQ.delete();
    fbQ.delete();
    applyStimulus(3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
